// File: rtl/pc_sequencer.sv
// Program-counter sequencer: reset entry select, increment, branch, single-level interrupt with EPC.
// Optional misaligned-branch trap enabled by defining PC_ALIGN_TRAP_EN.
module pc_sequencer #(
    parameter int unsigned      WIDTH        = 32,
    parameter int unsigned      STEP         = 4,
    parameter int unsigned      NUM_PROGRAMS = 2,
    parameter int unsigned      PROG_SEL_W   = 1,
    parameter logic [WIDTH-1:0] RESET_BASE   = '0,
    parameter int unsigned      PROG_STRIDE  = 10,
    parameter logic [WIDTH-1:0] IRQ_VECTOR   = 'h80,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = 'hC0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [PROG_SEL_W-1:0] prog_sel,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [WIDTH-1:0]      branch_target,
    input  logic                  irq_req,
    input  logic                  eret,
    output logic [WIDTH-1:0]      pc,
    output logic [WIDTH-1:0]      epc,
    output logic                  in_isr,
    output logic                  irq_ack,
    output logic                  align_fault
);

    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(STEP_W - WIDTH'(1));

    typedef enum logic {RUN, ISR} state_t;

    state_t                  state, state_n;
    logic [WIDTH-1:0]        pc_n, epc_n;
    logic                    ack_n, fault_n;
    logic [PROG_SEL_W-1:0]   sel_c;
    logic [WIDTH-1:0]        entry_c;
    logic [WIDTH-1:0]        nxt_c;
    logic                    trap_c;

    // Out-of-range program selects fall back to program 0.
    assign sel_c   = (32'(prog_sel) < NUM_PROGRAMS) ? prog_sel : '0;
    assign entry_c = RESET_BASE + WIDTH'(sel_c) * WIDTH'(PROG_STRIDE);
    assign nxt_c   = branch_taken ? (branch_target & ALIGN_MASK) : (pc + STEP_W);

`ifdef PC_ALIGN_TRAP_EN
    assign trap_c = (state == RUN) && branch_taken && ((branch_target & ~ALIGN_MASK) != '0);
`else
    assign trap_c = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= RUN;
            pc          <= entry_c;
            epc         <= '0;
            in_isr      <= 1'b0;
            irq_ack     <= 1'b0;
            align_fault <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            epc         <= epc_n;
            in_isr      <= (state_n == ISR);
            irq_ack     <= ack_n;
            align_fault <= fault_n;
        end
    end

    // Next-state selection in priority order: stall, trap, irq entry, eret, sequential/branch.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        epc_n   = epc;
        ack_n   = 1'b0;
        fault_n = 1'b0;
        if (!stall) begin
            if (trap_c) begin
                epc_n   = pc;
                pc_n    = TRAP_VECTOR;
                state_n = ISR;
                fault_n = 1'b1;
            end else if ((state == RUN) && irq_req) begin
                epc_n   = nxt_c;
                pc_n    = IRQ_VECTOR;
                state_n = ISR;
                ack_n   = 1'b1;
            end else if ((state == ISR) && eret) begin
                pc_n    = epc;
                state_n = RUN;
            end else begin
                pc_n    = nxt_c;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random traffic against a reference model.
module tb_pc_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  prog_sel;
    logic        stall, branch_taken, irq_req, eret;
    logic [31:0] branch_target;
    logic [31:0] pc, epc;
    logic        in_isr, irq_ack, align_fault;

    int errors = 0;
    int checks = 0;

    // Reference state
    logic [31:0] m_pc, m_epc;
    logic        m_isr, m_ack, m_fault;

    pc_sequencer #(.WIDTH(32), .PROG_SEL_W(2)) dut (
        .clock(clock), .reset(reset), .prog_sel(prog_sel), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .irq_req(irq_req), .eret(eret), .pc(pc), .epc(epc),
        .in_isr(in_isr), .irq_ack(irq_ack), .align_fault(align_fault)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Behavioural model of one clock edge, written from the architectural rules.
    task automatic model_step();
        logic [31:0] nxt;
        logic        trap;
        nxt  = branch_taken ? (branch_target & 32'hFFFF_FFFC) : (m_pc + 32'd4);
        trap = 1'b0;
`ifdef PC_ALIGN_TRAP_EN
        trap = !m_isr && branch_taken && (branch_target % 4 != 0);
`endif
        m_ack   = 1'b0;
        m_fault = 1'b0;
        if (reset) begin
            m_pc  = (prog_sel < 2) ? 32'(prog_sel) * 32'd10 : 32'd0;
            m_epc = 32'd0;
            m_isr = 1'b0;
        end else if (stall) begin
            // everything holds
        end else if (trap) begin
            m_epc = m_pc; m_pc = 32'hC0; m_isr = 1'b1; m_fault = 1'b1;
        end else if (!m_isr && irq_req) begin
            m_epc = nxt; m_pc = 32'h80; m_isr = 1'b1; m_ack = 1'b1;
        end else if (m_isr && eret) begin
            m_pc = m_epc; m_isr = 1'b0;
        end else begin
            m_pc = nxt;
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clock);
        #1;
        check("pc", pc, m_pc);
        check("epc", epc, m_epc);
        check("in_isr", 32'(in_isr), 32'(m_isr));
        check("irq_ack", 32'(irq_ack), 32'(m_ack));
        check("align_fault", 32'(align_fault), 32'(m_fault));
    endtask

    task automatic idle();
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        irq_req = 1'b0; eret = 1'b0; prog_sel = 2'd0;
    endtask

    initial begin
        m_pc = '0; m_epc = '0; m_isr = 1'b0; m_ack = 1'b0; m_fault = 1'b0;
        idle();

        // Reset entry points
        reset = 1'b1; prog_sel = 2'd1; cyc(); check("rst_prog1", pc, 32'd10);
        prog_sel = 2'd0; cyc(); check("rst_prog0", pc, 32'd0);
        prog_sel = 2'd3; cyc(); check("rst_prog3", pc, 32'd0);
        check("rst_epc", epc, 32'd0);
        check("rst_isr", 32'(in_isr), 32'd0);

        // Sequential run, stall, wrap
        idle();
        cyc(); check("inc1", pc, 32'd4);
        cyc(); check("inc2", pc, 32'd8);
        cyc(); check("inc3", pc, 32'd12);
        stall = 1'b1; cyc(); cyc(); check("stall_hold", pc, 32'd12);
        stall = 1'b0; branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC; cyc();
        check("br_top", pc, 32'hFFFF_FFFC);
        branch_taken = 1'b0; cyc(); check("wrap", pc, 32'd0);

        // Branch + irq in the same cycle
        cyc(); cyc(); check("at8", pc, 32'd8);
        branch_taken = 1'b1; branch_target = 32'h40; irq_req = 1'b1; cyc();
        check("entry_pc", pc, 32'h80);
        check("entry_epc", epc, 32'h40);
        check("entry_ack", 32'(irq_ack), 32'd1);
        check("entry_isr", 32'(in_isr), 32'd1);
        branch_taken = 1'b0; cyc(); check("isr_84", pc, 32'h84);
        check("ack_pulse", 32'(irq_ack), 32'd0);
        cyc(); check("isr_88", pc, 32'h88);
        check("isr_noack", 32'(irq_ack), 32'd0);
        eret = 1'b1; cyc(); check("eret_pc", pc, 32'h40);
        check("eret_isr", 32'(in_isr), 32'd0);
        eret = 1'b0; cyc(); check("reentry_pc", pc, 32'h80);
        check("reentry_ack", 32'(irq_ack), 32'd1);

        // Stall blocks a pending irq
        irq_req = 1'b0; eret = 1'b1; cyc(); check("eret2", pc, 32'h44);
        eret = 1'b0; stall = 1'b1; irq_req = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        check("stall_irq_pc", pc, 32'h44);
        check("stall_irq_ack", 32'(irq_ack), 32'd0);
        stall = 1'b0; cyc(); check("post_stall_pc", pc, 32'h80);
        check("post_stall_ack", 32'(irq_ack), 32'd1);

        // Misaligned branch target
        idle(); reset = 1'b1; cyc();
        reset = 1'b0; cyc(); cyc();
        branch_taken = 1'b1; branch_target = 32'h42; cyc();
`ifdef PC_ALIGN_TRAP_EN
        check("trap_pc", pc, 32'hC0);
        check("trap_epc", epc, 32'd8);
        check("trap_fault", 32'(align_fault), 32'd1);
`else
        check("align_pc", pc, 32'h40);
        check("align_fault", 32'(align_fault), 32'd0);
`endif

        // Reset inside ISR
        idle(); irq_req = 1'b1; cyc(); cyc();
        check("in_isr_pre", 32'(in_isr), 32'd1);
        irq_req = 1'b0; reset = 1'b1; cyc();
        check("rst_isr_exit", 32'(in_isr), 32'd0);
        check("rst_isr_epc", epc, 32'd0);

        // Random traffic
        idle();
        for (int i = 0; i < 400; i++) begin
            reset         = ($urandom_range(0, 49) == 0);
            prog_sel      = 2'($urandom_range(0, 3));
            stall         = ($urandom_range(0, 5) == 0);
            branch_taken  = ($urandom_range(0, 3) == 0);
            branch_target = $urandom();
            irq_req       = ($urandom_range(0, 7) == 0);
            eret          = ($urandom_range(0, 5) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
